// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface. It accepts pipelined requests
// into a word RAM and answers them in order after a fixed minimum latency.
module sram_like_responder #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic                       wr,
  input  logic [1:0]                 size,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic [3:0]                 wstrb,
  output logic [31:0]                rdata,
  output logic                       addr_ok,
  output logic                       data_ok,
  input  logic                       stall_i,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [3:0]    CNT_INIT = 4'(LATENCY - 1);
  localparam logic [OW-1:0] FULL     = OW'(DEPTH);

  logic [31:0]       mem [2**ADDR_W];

  logic              q_valid [DEPTH];
  logic              q_wr    [DEPTH];
  logic [1:0]        q_size  [DEPTH];
  logic [31:0]       q_rdata [DEPTH];
  logic [3:0]        q_cnt   [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              retire;
  logic              unused_bits;

  assign idx = addr[ADDR_W+1:2];

  // No bypass: a full queue refuses even when the head retires in the same cycle.
  assign addr_ok = !rst && req && (outstanding < FULL);
  assign accept  = addr_ok;

  assign data_ok = !rst && q_valid[rd_ptr] && (q_cnt[rd_ptr] == 4'd0) && !stall_i;
  assign retire  = data_ok;
  assign rdata   = (data_ok && !q_wr[rd_ptr]) ? q_rdata[rd_ptr] : 32'h0;

  // Size is kept with the entry for observability only; upper address bits alias.
  assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0], q_size[rd_ptr]};

  // Word RAM: byte-lane writes, never reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_valid[i] <= 1'b0;
        q_wr[i]    <= 1'b0;
        q_size[i]  <= 2'd0;
        q_rdata[i] <= 32'h0;
        q_cnt[i]   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
      end

      if (retire) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end

      // Read data is captured now, so a later write cannot change an accepted read.
      if (accept) begin
        q_valid[wr_ptr] <= 1'b1;
        q_wr[wr_ptr]    <= wr;
        q_size[wr_ptr]  <= size;
        q_rdata[wr_ptr] <= wr ? 32'h0 : mem[idx];
        q_cnt[wr_ptr]   <= CNT_INIT;
        wr_ptr          <= wr_ptr + PW'(1);
      end

      case ({accept, retire})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed scenarios plus randomized alias traffic, all checked
// against a transaction-level model (word array + queue of ready-cycle/expected-data pairs).
module tb_sram_like_responder;

  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int OW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic          stall_i = 1'b0;
  logic [1:0]    size = 2'd2;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic [3:0]    wstrb = 4'h0;
  logic [31:0]   rdata;
  logic          addr_ok;
  logic          data_ok;
  logic [OW-1:0] outstanding;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: memory image, plus per outstanding request its ready cycle and answer.
  logic [31:0] mem_m [2**ADDR_W];
  int          rdy_q[$];
  logic [31:0] exp_q[$];
  logic        exp_addr_ok;
  logic        exp_data_ok;
  logic [31:0] exp_rdata;

  sram_like_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .stall_i(stall_i),
    .outstanding(outstanding)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model prediction for the current cycle, taken away from the clock edge.
  task automatic sample();
    @(negedge clk);
    exp_addr_ok = !rst && req && (rdy_q.size() < DEPTH);
    exp_data_ok = !rst && rdy_q.size() > 0 && rdy_q[0] <= cyc && !stall_i;
    exp_rdata   = exp_data_ok ? exp_q[0] : 32'h0;
  endtask

  // Model update for the edge that ends the current cycle.
  task automatic commit();
    int          w;
    logic [31:0] tmp;
    if (exp_data_ok) begin
      void'(rdy_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (exp_addr_ok) begin
      w = int'(addr[ADDR_W+1:2]);
      rdy_q.push_back(cyc + LATENCY);
      if (wr) begin
        exp_q.push_back(32'h0);
        tmp = mem_m[w];
        for (int b = 0; b < 4; b++) if (wstrb[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
        mem_m[w] = tmp;
      end else begin
        exp_q.push_back(mem_m[w]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = 1'b1;
    #2;
    checks++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rdata !== 32'h0 || outstanding !== '0) begin
      errors++;
      $display("FAIL reset: addr_ok=%b data_ok=%b rdata=%h out=%0d, need all 0",
               addr_ok, data_ok, rdata, outstanding);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Full write then read of the same word; write answer carries rdata 0.
  task automatic test_write_read();
    req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'h1234_5678; wstrb = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin wr = 1'b0; wdata = 32'h0; wstrb = 4'h0; end
      if (k == 2) req = 1'b0;
      sample();
      checks++;
      if (addr_ok !== exp_addr_ok || data_ok !== exp_data_ok || rdata !== exp_rdata ||
          outstanding !== OW'(rdy_q.size())) begin
        errors++;
        $display("FAIL write_read k%0d: got ok=%b dok=%b rdata=%h out=%0d, exp ok=%b dok=%b rdata=%h out=%0d",
                 k, addr_ok, data_ok, rdata, outstanding, exp_addr_ok, exp_data_ok, exp_rdata, rdy_q.size());
      end
      if (k == 2) begin
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h0) begin
          errors++;
          $display("FAIL write_ans: data_ok=%b rdata=%h, need 1 / 00000000", data_ok, rdata);
        end
      end
      if (k == 3) begin
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h1234_5678) begin
          errors++;
          $display("FAIL read_ans: data_ok=%b rdata=%h, need 1 / 12345678", data_ok, rdata);
        end
      end
      commit();
    end
  endtask

  // Strobes alone select lanes.
  task automatic test_partial_write();
    req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'hAABB_CCDD; wstrb = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin wr = 1'b0; wdata = 32'h0; wstrb = 4'h0; end
      if (k == 2) req = 1'b0;
      sample();
      checks++;
      if (addr_ok !== exp_addr_ok || data_ok !== exp_data_ok || rdata !== exp_rdata ||
          outstanding !== OW'(rdy_q.size())) begin
        errors++;
        $display("FAIL partial k%0d: got ok=%b dok=%b rdata=%h out=%0d, exp ok=%b dok=%b rdata=%h out=%0d",
                 k, addr_ok, data_ok, rdata, outstanding, exp_addr_ok, exp_data_ok, exp_rdata, rdy_q.size());
      end
      if (k == 3) begin
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h12BB_56DD) begin
          errors++;
          $display("FAIL partial_ans: data_ok=%b rdata=%h, need 1 / 12bb56dd", data_ok, rdata);
        end
      end
      commit();
    end
  endtask

  // Six held reads under stall fill the queue; release gives retire-then-accept with no bypass.
  task automatic test_back_to_back();
    int n_acc = 0;
    req = 1'b1; wr = 1'b0; addr = 32'h40; stall_i = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 6) stall_i = 1'b0;
      sample();
      checks++;
      if (addr_ok !== exp_addr_ok || data_ok !== exp_data_ok || rdata !== exp_rdata ||
          outstanding !== OW'(rdy_q.size())) begin
        errors++;
        $display("FAIL b2b k%0d: got ok=%b dok=%b rdata=%h out=%0d, exp ok=%b dok=%b rdata=%h out=%0d",
                 k, addr_ok, data_ok, rdata, outstanding, exp_addr_ok, exp_data_ok, exp_rdata, rdy_q.size());
      end
      if (k < 6) begin
        checks++;
        if (addr_ok !== (k < 4) || data_ok !== 1'b0) begin
          errors++;
          $display("FAIL b2b_fill k%0d: addr_ok=%b data_ok=%b, need %b / 0", k, addr_ok, data_ok, k < 4);
        end
      end
      if (k == 6) begin
        checks++;
        if (addr_ok !== 1'b0 || data_ok !== 1'b1 || outstanding !== OW'(DEPTH)) begin
          errors++;
          $display("FAIL full_retire: addr_ok=%b data_ok=%b out=%0d, need 0 / 1 / %0d",
                   addr_ok, data_ok, outstanding, DEPTH);
        end
      end
      if (k >= 7 && k <= 9) begin
        checks++;
        if (data_ok !== 1'b1 || (k == 7 && addr_ok !== 1'b1)) begin
          errors++;
          $display("FAIL b2b_drain k%0d: addr_ok=%b data_ok=%b, need data_ok 1", k, addr_ok, data_ok);
        end
      end
      if (addr_ok) n_acc++;
      commit();
      if (n_acc == 6) req = 1'b0;
    end
  endtask

  // Asynchronous reset with requests in flight; they must never be answered.
  task automatic test_reset_mid();
    req = 1'b1; wr = 1'b0; addr = 32'h40; stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++;
      if (addr_ok !== exp_addr_ok || outstanding !== OW'(rdy_q.size())) begin
        errors++;
        $display("FAIL rst_fill k%0d: addr_ok=%b out=%0d, exp %b / %0d",
                 k, addr_ok, outstanding, exp_addr_ok, rdy_q.size());
      end
      commit();
    end
    stall_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    rdy_q.delete();
    exp_q.delete();
    checks++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rdata !== 32'h0 || outstanding !== '0) begin
      errors++;
      $display("FAIL rst_mid: addr_ok=%b data_ok=%b rdata=%h out=%0d, need all 0",
               addr_ok, data_ok, rdata, outstanding);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      checks++;
      if (data_ok !== 1'b0 || outstanding !== '0) begin
        errors++;
        $display("FAIL rst_quiet k%0d: data_ok=%b out=%0d, need 0 / 0", k, data_ok, outstanding);
      end
      commit();
    end
    req = 1'b1; wr = 1'b0; addr = 32'h40;
    for (int k = 0; k <= LATENCY + 1; k++) begin
      if (k == 1) req = 1'b0;
      sample();
      checks++;
      if (addr_ok !== exp_addr_ok || data_ok !== exp_data_ok || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rst_fresh k%0d: got ok=%b dok=%b rdata=%h, exp ok=%b dok=%b rdata=%h",
                 k, addr_ok, data_ok, rdata, exp_addr_ok, exp_data_ok, exp_rdata);
      end
      if (k == LATENCY) begin
        checks++;
        if (data_ok !== 1'b1 || rdata !== 32'h12BB_56DD) begin
          errors++;
          $display("FAIL rst_fresh_ans: data_ok=%b rdata=%h, need 1 / 12bb56dd", data_ok, rdata);
        end
      end
      commit();
    end
  endtask

  // Random write/read pairs over two aliasing addresses with random stall and offsets.
  task automatic test_alias_random();
    int guard;
    logic acc;
    for (int i = 0; i < 40; i++) begin
      for (int op = 0; op < 2; op++) begin
        req   = 1'b1;
        wr    = (op == 0);
        addr  = ($urandom_range(0, 1) ? 32'h1000 : 32'h0) | 32'($urandom_range(0, 3));
        size  = 2'($urandom_range(0, 2));
        wdata = wr ? $urandom : 32'h0;
        wstrb = !wr ? 4'h0 : (i == 0) ? 4'hF : 4'($urandom_range(0, 15));
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 50) begin
          stall_i = ($urandom_range(0, 3) == 0);
          sample();
          checks++;
          if (addr_ok !== exp_addr_ok || data_ok !== exp_data_ok || rdata !== exp_rdata ||
              outstanding !== OW'(rdy_q.size())) begin
            errors++;
            $display("FAIL alias i%0d op%0d: got ok=%b dok=%b rdata=%h out=%0d, exp ok=%b dok=%b rdata=%h out=%0d",
                     i, op, addr_ok, data_ok, rdata, outstanding, exp_addr_ok, exp_data_ok, exp_rdata, rdy_q.size());
          end
          acc = addr_ok;
          commit();
          guard++;
        end
        if (!acc) begin
          checks++;
          errors++;
          $display("FAIL alias_accept i%0d op%0d: no addr_ok within 50 cycles", i, op);
        end
        if ($urandom_range(0, 2) == 0) begin
          req = 1'b0;
          sample();
          checks++;
          if (data_ok !== exp_data_ok || rdata !== exp_rdata) begin
            errors++;
            $display("FAIL alias_gap i%0d: got dok=%b rdata=%h, exp dok=%b rdata=%h",
                     i, data_ok, rdata, exp_data_ok, exp_rdata);
          end
          commit();
        end
      end
    end
    req = 1'b0;
    stall_i = 1'b0;
    guard = 0;
    while (rdy_q.size() > 0 && guard < 50) begin
      sample();
      checks++;
      if (data_ok !== exp_data_ok || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL alias_drain: got dok=%b rdata=%h, exp dok=%b rdata=%h",
                 data_ok, rdata, exp_data_ok, exp_rdata);
      end
      commit();
      guard++;
    end
    checks++;
    if (outstanding !== '0 || rdy_q.size() != 0) begin
      errors++;
      $display("FAIL alias_empty: out=%0d model=%0d, need 0", outstanding, rdy_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_reset_mid();
    test_alias_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
